bg_layer_mixer: RTL and testbench

//  Downstream of the four-layer background pipeline group. Takes the per-layer pixel streams, removes
//  the staggered per-layer start skew (0,1,6,7 cycles), resolves layer priority per pixel and emits
//  one composited pixel per clock for the active span of a scanline, with pixel-x and end-of-line flag.

---
 rtl/bg_layer_mixer_pkg.sv | 22 ++
 rtl/bg_layer_mixer_if.sv | 35 +++
 rtl/bg_skew_delay.sv | 33 +++
 rtl/bg_layer_mixer.sv | 130 +++++++++++++
 tb/tb_bg_layer_mixer.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bg_layer_mixer_pkg.sv
// Shared types and constants for the background layer mixer (package bg_mix_pkg).
// Layer skews describe how many cycles after layer 0 each raw layer stream starts.
package bg_mix_pkg;

  localparam int NUM_LAYERS = 4;
  localparam int MAX_SKEW   = 7;
  localparam int LAYER_SKEW [NUM_LAYERS] = '{0, 1, 6, 7};

  typedef logic [1:0] layer_id_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACTIVE = 2'd2
  } mix_state_e;

  // Delay that brings a layer into step with the most-skewed layer.
  function automatic int skew_depth(input int layer);
    return MAX_SKEW - LAYER_SKEW[layer];
  endfunction

endpackage

// File: rtl/bg_layer_mixer_if.sv
// Pixel-stream bundle between the layer pipelines and the mixer.
// Optional layer_enable exists only when LAYER_MASK_EN is defined.
interface bg_layer_mixer_if #(
  parameter int PIX_W = 4
);
  // Streaming without backpressure: pix_out/pix_x/line_done are meaningful only
  // in cycles where pix_valid is high; the consumer must accept every such cycle.
  logic                 line_starting;
  logic [4*PIX_W-1:0]   layer_pix;
  logic [7:0]           layer_priority;
  logic [PIX_W-1:0]     backdrop;
`ifdef LAYER_MASK_EN
  logic [3:0]           layer_enable;
`endif
  logic [PIX_W+1:0]     pix_out;
  logic                 pix_valid;
  logic [8:0]           pix_x;
  logic                 line_done;

  modport master (
    output line_starting, layer_pix, layer_priority, backdrop,
`ifdef LAYER_MASK_EN
           layer_enable,
`endif
    input  pix_out, pix_valid, pix_x, line_done
  );

  modport slave (
    input  line_starting, layer_pix, layer_priority, backdrop,
`ifdef LAYER_MASK_EN
           layer_enable,
`endif
    output pix_out, pix_valid, pix_x, line_done
  );
endinterface

// File: rtl/bg_skew_delay.sv
// Fixed-depth register delay line; DEPTH=0 degenerates to a plain wire.
module bg_skew_delay #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign q_o = d_i;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/bg_layer_mixer.sv
// Aligns four skewed background layers, resolves priority and emits one pixel per clock.
// Build option LAYER_MASK_EN adds a per-line layer enable mask.
module bg_layer_mixer
  import bg_mix_pkg::*;
#(
  parameter int PIX_W       = 4,
  parameter int LINE_PIXELS = 320,
  parameter int FIRST_LAT   = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  bg_layer_mixer_if.slave mix_if,
  output mix_state_e   state_o
);

  localparam int              CNT_W    = $clog2(FIRST_LAT + MAX_SKEW + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FIRST_LAT + MAX_SKEW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [8:0]       LAST_X   = 9'(LINE_PIXELS - 1);

  if (LINE_PIXELS > 512 || LINE_PIXELS < 1) begin : g_bad_line_pixels
    $error("bg_layer_mixer: LINE_PIXELS must be 1..512");
  end

  mix_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [8:0]       x_q;
  logic [7:0]       prio_q;
  logic [PIX_W+1:0] pix_out_q;
  logic             pix_valid_q;
  logic [8:0]       pix_x_q;
  logic             line_done_q;
  logic [3:0]       layer_en;

  logic [PIX_W-1:0] aligned [NUM_LAYERS];
  logic [PIX_W+1:0] win_d;
  logic             found;
  layer_id_t        rank_id;
  logic             last_x;
  logic             emit;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    bg_skew_delay #(
      .WIDTH (PIX_W),
      .DEPTH (skew_depth(g))
    ) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (mix_if.layer_pix[g*PIX_W +: PIX_W]),
      .q_o   (aligned[g])
    );
  end

`ifdef LAYER_MASK_EN
  logic [3:0] mask_q;
  assign layer_en = mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    mask_q <= 4'hF;
    else if (mix_if.line_starting) mask_q <= mix_if.layer_enable;
  end
`else
  assign layer_en = 4'hF;
`endif

  // Highest-ranked enabled opaque layer wins; duplicate ranks simply re-test the same layer.
  always_comb begin
    win_d   = {2'd0, mix_if.backdrop};
    found   = 1'b0;
    rank_id = '0;
    for (int r = 0; r < NUM_LAYERS; r++) begin
      rank_id = prio_q[2*r +: 2];
      if (!found && layer_en[rank_id] && (aligned[rank_id] != '0)) begin
        found = 1'b1;
        win_d = {rank_id, aligned[rank_id]};
      end
    end
  end

  assign last_x = (x_q == LAST_X);
  // A restart strobe kills the in-flight pixel unless it is the last one of the line.
  assign emit   = (state_q == ACTIVE) && (!mix_if.line_starting || last_x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      prio_q      <= 8'b11_10_01_00;
      pix_out_q   <= '0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      line_done_q <= 1'b0;
    end else begin
      pix_valid_q <= emit;
      pix_out_q   <= emit ? win_d : '0;
      pix_x_q     <= emit ? x_q : '0;
      line_done_q <= (state_q == ACTIVE) && last_x;

      case (state_q)
        IDLE: ;
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_ONE) begin
            state_q <= ACTIVE;
            x_q     <= '0;
          end
        end
        ACTIVE: begin
          x_q <= x_q + 1'b1;
          if (last_x) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (mix_if.line_starting) begin
        state_q <= WAIT;
        cnt_q   <= CNT_LOAD;
        prio_q  <= mix_if.layer_priority;
      end
    end
  end

  assign mix_if.pix_out   = pix_out_q;
  assign mix_if.pix_valid = pix_valid_q;
  assign mix_if.pix_x     = pix_x_q;
  assign mix_if.line_done = line_done_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_bg_layer_mixer.sv
// Bench for bg_layer_mixer: scoreboard of expected pixels plus per-scenario inline checks.
// Define LAYER_MASK_EN to also exercise the layer enable mask.
module tb_bg_layer_mixer;
  import bg_mix_pkg::*;

  localparam int LINE  = 320;
  localparam int FLAT  = 10;
  localparam int LAT   = FLAT + 8;
  localparam int TB_SKEW [4] = '{0, 1, 6, 7};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  mix_state_e state_dbg;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  bg_layer_mixer_if #(.PIX_W(4)) mif ();

  bg_layer_mixer #(
    .PIX_W       (4),
    .LINE_PIXELS (LINE),
    .FIRST_LAT   (FLAT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mix_if  (mif),
    .state_o (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_word(input logic [1:0] id, input logic [3:0] col,
                                           input logic [8:0] x, input logic done);
    return {id, col, x, done};
  endfunction

  task automatic push_line(input logic [1:0] id, input logic [3:0] col, input int n);
    for (int x = 0; x < n; x++) exp_q.push_back(exp_word(id, col, 9'(x), x == LINE - 1));
  endtask

  task automatic strobe();
    mif.line_starting = 1'b1;
    @(posedge clk);
    #1 mif.line_starting = 1'b0;
  endtask

  // Scoreboard: every valid output pixel must match the oldest expected entry.
  always @(negedge clk) begin
    logic [15:0] got, exp;
    if (rst_n && mif.pix_valid) begin
      got = {mif.pix_out, mif.pix_x, mif.line_done};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pixel got id=%0d col=%h x=%0d done=%b, none expected",
                 got[15:14], got[13:10], got[9:1], got[0]);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL pixel got id=%0d col=%h x=%0d done=%b exp id=%0d col=%h x=%0d done=%b",
                   got[15:14], got[13:10], got[9:1], got[0],
                   exp[15:14], exp[13:10], exp[9:1], exp[0]);
        end
      end
    end
    if (rst_n && mif.line_done && !mif.pix_valid) begin
      checks++;
      errors++;
      $display("FAIL line_done_without_valid got done=1 valid=0 exp done=0");
    end
  end

  task automatic wait_latency(input string name);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mif.pix_valid && lat < 100);
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL %s_latency got %0d exp %0d", name, lat, LAT);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending exp 0", name, exp_q.size());
    end
    @(negedge clk);
    checks++;
    if (mif.pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_after got valid=%b exp 0", name, mif.pix_valid);
    end
  endtask

  task automatic test_reset();
    mif.line_starting  = 1'b0;
    mif.layer_pix      = 16'h4321;
    mif.layer_priority = 8'b11_10_01_00;
    mif.backdrop       = 4'h7;
`ifdef LAYER_MASK_EN
    mif.layer_enable   = 4'hF;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mif.pix_valid !== 1'b0 || mif.pix_out !== 6'd0 || mif.pix_x !== 9'd0 ||
        mif.line_done !== 1'b0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b out=%h x=%0d done=%b st=%0d exp all 0",
               mif.pix_valid, mif.pix_out, mif.pix_x, mif.line_done, state_dbg);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      checks++;
      if (mif.pix_valid !== 1'b0 || mif.pix_out !== 6'd0 || mif.line_done !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet cycle %0d got valid=%b out=%h done=%b exp 0 0 0",
                 k, mif.pix_valid, mif.pix_out, mif.line_done);
      end
    end
  endtask

  task automatic test_basic_line();
    mif.layer_pix      = 16'h4321;
    mif.layer_priority = 8'b11_10_01_00;
    push_line(2'd0, 4'h1, LINE);
    strobe();
    wait_latency("basic");
    drain("basic");
  endtask

  task automatic test_priority();
    logic [7:0]  prio [4];
    logic [15:0] pix  [4];
    logic [1:0]  eid  [4];
    logic [3:0]  ecol [4];
    prio[0] = 8'b00_01_11_10; pix[0] = 16'h9500; eid[0] = 2'd2; ecol[0] = 4'h5;
    prio[1] = 8'b00_01_10_11; pix[1] = 16'h9500; eid[1] = 2'd3; ecol[1] = 4'h9;
    prio[2] = 8'b00_01_10_11; pix[2] = 16'h0000; eid[2] = 2'd0; ecol[2] = 4'h7;
    prio[3] = 8'b00_00_01_01; pix[3] = 16'h6503; eid[3] = 2'd0; ecol[3] = 4'h3;
    mif.backdrop = 4'h7;
    for (int t = 0; t < 4; t++) begin
      mif.layer_pix      = pix[t];
      mif.layer_priority = prio[t];
      push_line(eid[t], ecol[t], LINE);
      strobe();
      drain("priority");
    end
  endtask

  task automatic test_skew();
    logic [7:0]  p;
    logic [15:0] pix;
    mif.backdrop = 4'h2;
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < 4; r++) p[2*r +: 2] = 2'((t + r) % 4);
      mif.layer_priority = p;
      mif.layer_pix      = 16'h0000;
      for (int x = 0; x < LINE; x++)
        exp_q.push_back(x == 5 ? exp_word(2'(t), 4'(10 + t), 9'(x), 1'b0)
                               : exp_word(2'd0, 4'h2, 9'(x), x == LINE - 1));
      strobe();
      for (int n = 1; n <= 30; n++) begin
        pix = '0;
        for (int i = 0; i < 4; i++)
          if (n == FLAT + TB_SKEW[i] + 5) pix[i*4 +: 4] = 4'(10 + i);
        mif.layer_pix = pix;
        @(posedge clk);
        #1;
      end
      drain("skew");
    end
  endtask

  task automatic test_back_to_back();
    bit hit;
    mif.layer_pix      = 16'h4321;
    mif.layer_priority = 8'b11_10_01_00;
    mif.backdrop       = 4'h7;
    // Aborted line: pixels 0..100 only, then a fresh line.
    push_line(2'd0, 4'h1, 101);
    strobe();
    hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(negedge clk);
      if (mif.pix_valid && mif.pix_x == 9'd100) hit = 1'b1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL abort_find_x100 got none exp x=100"); end
    push_line(2'd0, 4'h1, LINE);
    strobe();
    @(negedge clk);
    checks++;
    if (mif.pix_valid !== 1'b0 || mif.line_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop got valid=%b done=%b exp 0 0", mif.pix_valid, mif.line_done);
    end
    begin : relat
      int lat;
      lat = 1;
      while (!mif.pix_valid && lat < 100) begin @(negedge clk); lat++; end
      checks++;
      if (lat !== LAT) begin errors++; $display("FAIL abort_relatency got %0d exp %0d", lat, LAT); end
    end
    // Strobe coinciding with the final pixel: it is still emitted with line_done.
    hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(negedge clk);
      if (mif.pix_valid && mif.pix_x == 9'd318) hit = 1'b1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL last_find_x318 got none exp x=318"); end
    push_line(2'd0, 4'h1, LINE);
    strobe();
    @(negedge clk);
    checks++;
    if (mif.pix_valid !== 1'b1 || mif.line_done !== 1'b1 || mif.pix_x !== 9'd319) begin
      errors++;
      $display("FAIL last_pixel got valid=%b done=%b x=%0d exp 1 1 319",
               mif.pix_valid, mif.line_done, mif.pix_x);
    end
    begin : lastlat
      int lat;
      lat = 1;
      do begin @(negedge clk); lat++; end while (!mif.pix_valid && lat < 100);
      checks++;
      if (lat !== LAT) begin errors++; $display("FAIL last_relatency got %0d exp %0d", lat, LAT); end
    end
    drain("back_to_back");
  endtask

`ifdef LAYER_MASK_EN
  task automatic test_layer_mask();
    mif.layer_pix      = 16'h4321;
    mif.layer_priority = 8'b11_10_01_00;
    mif.layer_enable   = 4'b1110;
    push_line(2'd1, 4'h2, LINE);
    strobe();
    mif.layer_enable = 4'hF;
    drain("layer_mask");
  endtask
`endif

  task automatic test_reset_mid_line();
    bit hit;
    mif.layer_pix      = 16'h4321;
    mif.layer_priority = 8'b11_10_01_00;
    push_line(2'd0, 4'h1, LINE);
    strobe();
    hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(negedge clk);
      if (mif.pix_valid && mif.pix_x == 9'd50) hit = 1'b1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mif.pix_valid !== 1'b0 || mif.pix_out !== 6'd0 || mif.pix_x !== 9'd0 ||
        mif.line_done !== 1'b0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL async_reset got valid=%b out=%h x=%0d done=%b st=%0d exp all 0",
               mif.pix_valid, mif.pix_out, mif.pix_x, mif.line_done, state_dbg);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if (mif.pix_valid !== 1'b0) begin
        errors++;
        $display("FAIL no_resume cycle %0d got valid=%b exp 0", k, mif.pix_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_priority();
    test_skew();
    test_back_to_back();
`ifdef LAYER_MASK_EN
    test_layer_mask();
`endif
    test_reset_mid_line();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
